router_rr_scheduler: RTL

- Round-robin scheduler that shares the single-input 4-way router datapath between NUM_REQ independent requesters.
- Each requester presents data plus a 2-bit destination address over a valid/ready handshake.
- The scheduler grants at most one request per cycle, skipping requests whose destination is back-pressured.
- The granted word, its enable and its address are registered and drive the router's din, din_en and addr inputs.

---
 rtl/router_pkg.sv | 12 +
 rtl/router_rr_scheduler_rr_pick.sv | 36 +++
 rtl/router_rr_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router types and helpers for the scheduler slice.
package router_pkg;
  localparam int ADDR_W  = 2;
  localparam int NUM_DST = 4;

  typedef logic [ADDR_W-1:0] router_addr_t;

  // Bit offset of element idx in a packed vector of width-bit elements.
  function automatic int req_slice(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/router_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping.
// Zero latency; no state, no handshake of its own.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Wrapped segment first, then the segment at/after rr_ptr overrides it;
    // descending order leaves the lowest index of each segment as the winner.
    for (int j = N - 1; j >= 0; j--) begin
      if (eligible[j] && (j < int'(rr_ptr))) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        any_grant = 1'b1;
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (eligible[j] && (j >= int'(rr_ptr))) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/router_rr_scheduler.sv
// Round-robin scheduler sharing one router input among NUM_REQ requesters.
// One-cycle registered output; requesters to back-pressured destinations are skipped.
module router_rr_scheduler
  import router_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_REQ    = 4,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_DST-1:0]            dst_ready,
  output logic [DATA_WIDTH-1:0]         rt_din,
  output logic                          rt_din_en,
  output logic [ADDR_W-1:0]             rt_addr,
  output logic [IDX_W-1:0]              grant_id
);
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_grant;
  router_addr_t          addr_i;

  logic [IDX_W-1:0]      rr_ptr_d, rr_ptr_q;
  logic [DATA_WIDTH-1:0] rt_din_d, rt_din_q;
  logic                  rt_din_en_d, rt_din_en_q;
  router_addr_t          rt_addr_d, rt_addr_q;
  logic [IDX_W-1:0]      grant_id_d, grant_id_q;

  // Gating with resetn keeps req_ready low for the whole reset interval.
  always_comb begin
    eligible = '0;
    addr_i   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_i      = req_addr[req_slice(i, ADDR_W) +: ADDR_W];
      eligible[i] = resetn & arb_en & req_valid[i] & dst_ready[addr_i];
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rt_din_d    = '0;
    rt_din_en_d = 1'b0;
    rt_addr_d   = '0;
    grant_id_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rt_din_d  = req_data[req_slice(i, DATA_WIDTH) +: DATA_WIDTH];
        rt_addr_d = req_addr[req_slice(i, ADDR_W) +: ADDR_W];
      end
    end
    if (any_grant) begin
      rt_din_en_d = 1'b1;
      grant_id_d  = grant_idx;
      // Explicit wrap so non-power-of-two NUM_REQ works.
      rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q    <= '0;
      rt_din_q    <= '0;
      rt_din_en_q <= 1'b0;
      rt_addr_q   <= '0;
      grant_id_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rt_din_q    <= rt_din_d;
      rt_din_en_q <= rt_din_en_d;
      rt_addr_q   <= rt_addr_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign rt_din    = rt_din_q;
  assign rt_din_en = rt_din_en_q;
  assign rt_addr   = rt_addr_q;
  assign grant_id  = grant_id_q;
endmodule
